// File: rtl/herring_bus_ctrl_pkg.sv
// Shared types and constants for the herring bus controller: FSM states,
// address-slice width and the standard ACIA/VIA decode map.
package herring_bus_pkg;

  localparam int ADDR_W = 6;

  localparam logic [ADDR_W-1:0] ACIA_BASE = 6'b100000;
  localparam logic [ADDR_W-1:0] VIA_BASE  = 6'b100001;
  localparam logic [ADDR_W-1:0] STD_MASK  = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Masked compare of one window; bits with mask=0 are don't-care.
  function automatic logic cs_match(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/herring_bus_ctrl_if.sv
// CPU-side bus bundle: address/RWB/PHI2O from the CPU, PHI2/RDY/selects back.
interface herring_bus_ctrl_if #(
  parameter int NUM_CS = 8
);
  import herring_bus_pkg::*;

  logic              cpu_clk_out;
  logic              cpu_clk_in;
  logic [ADDR_W-1:0] address;
  logic              rw;
  logic [NUM_CS-1:0] decoder;
  logic              ram_we_n;
  logic              rdy;

  modport master (
    output cpu_clk_out, address, rw,
    input  cpu_clk_in, decoder, ram_we_n, rdy
  );

  modport slave (
    input  cpu_clk_out, address, rw,
    output cpu_clk_in, decoder, ram_we_n, rdy
  );

endinterface

// File: rtl/herring_bus_ctrl_clk_div.sv
// Divides the source oscillator into the CPU clock and flags the last
// source clock of each CPU cycle.
module herring_clk_div #(
  parameter int DIVISOR = 25
) (
  input  logic clk_src,
  input  logic reset,
  output logic o_cpu_clk,
  output logic o_eoc
);

  localparam int CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIVISOR / 2);

  logic [CNT_W-1:0] r_counter;
  logic             r_cpu_clk;

  // High phase uses the floor of DIVISOR/2, so odd divisors run short-high.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      r_counter <= '0;
      r_cpu_clk <= 1'b0;
    end else begin
      r_counter <= (r_counter == LAST) ? '0 : r_counter + 1'b1;
      r_cpu_clk <= (r_counter < HALF);
    end
  end

  assign o_cpu_clk = r_cpu_clk;
  assign o_eoc     = (r_counter == LAST);

endmodule

// File: rtl/herring_bus_ctrl.sv
// 65C02 glue: clock divider, prioritised chip-select decode, RAM write
// strobe, and RDY wait-state insertion for windows marked slow.
module herring_bus_ctrl
  import herring_bus_pkg::*;
#(
  parameter int                       DIVISOR     = 25,
  parameter int                       NUM_CS      = 8,
  parameter logic [ADDR_W*NUM_CS-1:0] CS_BASE     = {NUM_CS{6'h00}},
  parameter logic [ADDR_W*NUM_CS-1:0] CS_MASK     = {NUM_CS{6'h3F}},
  parameter logic [NUM_CS-1:0]        CS_EN       = '0,
  parameter logic [NUM_CS-1:0]        SLOW_MASK   = '0,
  parameter int                       WAIT_CYCLES = 0
) (
  input  logic               clk_src,
  input  logic               reset,
  herring_bus_ctrl_if.slave  bus
);

  localparam bit         STRETCH_EN = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_LOAD  = STRETCH_EN ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic              w_cpu_clk;
  logic              w_eoc;
  logic [NUM_CS-1:0] w_hit;
  logic [NUM_CS-1:0] w_win;
  logic              w_found;
  logic              w_slow_hit;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rdy;
  logic              w_rdy_nxt;
  logic [3:0]        r_wcnt;
  logic [3:0]        w_wcnt_nxt;

  herring_clk_div #(
    .DIVISOR (DIVISOR)
  ) u_div (
    .clk_src   (clk_src),
    .reset     (reset),
    .o_cpu_clk (w_cpu_clk),
    .o_eoc     (w_eoc)
  );

  // Lowest-index enabled hit wins, giving at most one active select.
  always_comb begin
    w_hit   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CS; i++) begin
      w_hit[i] = CS_EN[i] &
                 cs_match(bus.address, CS_BASE[ADDR_W*i +: ADDR_W],
                          CS_MASK[ADDR_W*i +: ADDR_W]);
      if (w_hit[i] && !w_found) begin
        w_win[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_slow_hit   = |(w_win & SLOW_MASK);
  assign bus.decoder  = ~w_win;
  assign bus.ram_we_n = ~(bus.cpu_clk_out & ~bus.rw);
  assign bus.cpu_clk_in = w_cpu_clk;
  assign bus.rdy      = r_rdy;

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_rdy   <= 1'b1;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= w_rdy_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // DONE ignores slow_hit: it is the completing cycle of the stretched access.
  always_comb begin
    w_state_nxt = r_state;
    w_rdy_nxt   = r_rdy;
    w_wcnt_nxt  = r_wcnt;
    if (w_eoc) begin
      case (r_state)
        IDLE: begin
          if (w_slow_hit && STRETCH_EN) begin
            w_rdy_nxt   = 1'b0;
            w_wcnt_nxt  = WAIT_LOAD;
            w_state_nxt = WAIT;
          end else begin
            w_rdy_nxt   = 1'b1;
          end
        end
        WAIT: begin
          if (r_wcnt == 4'd0) begin
            w_rdy_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_wcnt_nxt  = r_wcnt - 4'd1;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_rdy_nxt   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_herring_bus_ctrl.sv
// Directed bench: divider waveform, decode priority, write strobe,
// wait-state sequence and reset in the middle of a stretch.
module tb_herring_bus_ctrl;
  import herring_bus_pkg::*;

  logic clk_src = 1'b0;
  logic reset   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_src = ~clk_src;

  herring_bus_ctrl_if #(.NUM_CS(2)) bus_a ();
  herring_bus_ctrl_if #(.NUM_CS(3)) bus_b ();

  herring_bus_ctrl #(
    .DIVISOR     (25),
    .NUM_CS      (2),
    .CS_BASE     ({VIA_BASE, ACIA_BASE}),
    .CS_MASK     ({STD_MASK, STD_MASK}),
    .CS_EN       (2'b11),
    .SLOW_MASK   (2'b10),
    .WAIT_CYCLES (2)
  ) dut_a (
    .clk_src (clk_src),
    .reset   (reset),
    .bus     (bus_a.slave)
  );

  herring_bus_ctrl #(
    .DIVISOR     (25),
    .NUM_CS      (3),
    .CS_BASE     ({6'h00, VIA_BASE, 6'h20}),
    .CS_MASK     ({6'h00, STD_MASK, 6'h20}),
    .CS_EN       (3'b011),
    .SLOW_MASK   (3'b111),
    .WAIT_CYCLES (0)
  ) dut_b (
    .clk_src (clk_src),
    .reset   (reset),
    .bus     (bus_b.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_src);
    #1;
  endtask

  initial begin
    logic exp_rdy;
    bus_a.cpu_clk_out = 1'b0;
    bus_a.rw          = 1'b1;
    bus_a.address     = 6'b000000;
    bus_b.cpu_clk_out = 1'b0;
    bus_b.rw          = 1'b1;
    bus_b.address     = 6'b000000;

    #2 reset = 1'b1;
    #1;
    check_val("reset_rdy", bus_a.rdy, 1);
    check_val("reset_cpu_clk", bus_a.cpu_clk_in, 0);

    // Decode is combinational and valid while reset is held.
    bus_a.address = 6'b100001; #1; check_val("dec_via", bus_a.decoder, 2'b01);
    bus_a.address = 6'b100000; #1; check_val("dec_acia", bus_a.decoder, 2'b10);
    bus_a.address = 6'b000000; #1; check_val("dec_none", bus_a.decoder, 2'b11);

    bus_b.address = 6'b100001; #1; check_val("ovl_via", bus_b.decoder, 3'b110);
    bus_b.address = 6'b100000; #1; check_val("ovl_acia", bus_b.decoder, 3'b110);
    bus_b.address = 6'b000001; #1; check_val("ovl_disabled", bus_b.decoder, 3'b111);
    bus_b.address = 6'b000000; #1; check_val("ovl_none", bus_b.decoder, 3'b111);

    bus_a.cpu_clk_out = 1'b1; bus_a.rw = 1'b0; #1; check_val("we_write", bus_a.ram_we_n, 0);
    bus_a.rw = 1'b1; #1; check_val("we_read", bus_a.ram_we_n, 1);
    bus_a.cpu_clk_out = 1'b0; bus_a.rw = 1'b0; #1; check_val("we_phi_low", bus_a.ram_we_n, 1);
    bus_a.rw = 1'b1;

    tick;
    tick;
    reset = 1'b0;

    // Divider: 12 high, 13 low per 25-clock period, no stretching.
    for (int n = 1; n <= 100; n++) begin
      tick;
      check_val($sformatf("div_clk_%0d", n), bus_a.cpu_clk_in,
                (((n - 1) % 25) < 12) ? 1 : 0);
      check_val($sformatf("div_rdy_%0d", n), bus_a.rdy, 1);
    end

    // Slow window held: stretched 125..174, plain 175..224, stretched again at 225.
    bus_a.address = VIA_BASE;
    bus_b.address = 6'b100001;
    for (int n = 101; n <= 230; n++) begin
      tick;
      exp_rdy = !(((n >= 125) && (n < 175)) || (n >= 225));
      check_val($sformatf("slow_rdy_%0d", n), bus_a.rdy, exp_rdy);
      check_val($sformatf("nowait_rdy_%0d", n), bus_b.rdy, 1);
      if (n == 101) check_val("slow_dec", bus_a.decoder, 2'b01);
    end

    // Five clocks into the second stretch: async reset.
    reset = 1'b1;
    #1;
    check_val("rst_wait_rdy", bus_a.rdy, 1);
    check_val("rst_wait_clk", bus_a.cpu_clk_in, 0);
    check_val("rst_wait_cnt", dut_a.u_div.r_counter, 0);
    tick;
    check_val("rst_hold_rdy", bus_a.rdy, 1);
    reset = 1'b0;

    for (int n = 1; n <= 25; n++) begin
      tick;
      if (n == 1) check_val("rel_clk_1", bus_a.cpu_clk_in, 1);
      check_val($sformatf("rel_rdy_%0d", n), bus_a.rdy, (n < 25) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/herring_bus_ctrl.md
Name: herring_bus_ctrl

Overview:
Parametrised successor to the board's fixed glue decoder. It divides the source oscillator into the 65C02 clock and decodes NUM_CS parameterised address windows into active-low chip selects. It also drives the RAM write strobe. New: it inserts a programmable number of whole-CPU-cycle wait states, via the CPU RDY pin, whenever a window flagged as slow is accessed. It sits between the 50 MHz oscillator, the CPU and all peripheral selects.

Parameters:
DIVISOR, 25, source clocks per CPU cycle (50 MHz/25 = 2 MHz); legal range 2..2^16-1.
NUM_CS, 8, number of chip-select outputs; legal range 1..16.
CS_BASE, {NUM_CS{6'h00}} packed 6*NUM_CS, per-channel match value for address[15:10]; channel i uses bits [6i+5:6i].
CS_MASK, {NUM_CS{6'h3F}} packed 6*NUM_CS, per-channel care mask; 1 means the bit is compared.
CS_EN, all-zero NUM_CS bits, channel i is decodable only when CS_EN[i]=1; disabled channels are held at 1.
SLOW_MASK, all-zero NUM_CS bits, channel i requests wait states when set.
WAIT_CYCLES, 0, CPU cycles of RDY-low per slow access; legal range 0..15; 0 disables stretching.

Ports:
clk_src  input  1  50 MHz source clock; all state is on its rising edge.
reset  input  1  asynchronous, active-high reset.
cpu_clk_out  input  1  PHI2O returned from the CPU.
cpu_clk_in  output  1  registered CPU clock (PHI2 in).
address  input  6  CPU address[15:10].
rw  input  1  CPU RWB; 1 = read.
decoder  output  NUM_CS  active-low chip selects.
ram_we_n  output  1  active-low RAM write strobe.
rdy  output  1  CPU RDY; 0 = stall.

Behaviour:
- Reset (async assert, released on clk_src edge): counter=0, cpu_clk_in=0, rdy=1, state=IDLE, wcnt=0. decoder and ram_we_n are combinational and valid during reset.
- Divider: counter increments by 1 and wraps from DIVISOR-1 to 0. cpu_clk_in <= (counter < DIVISOR/2), integer division. Odd DIVISOR gives the shorter high phase.
- eoc strobe is combinational: (counter == DIVISOR-1). It marks the last source clock of a CPU cycle.
- Decode: hit[i] = CS_EN[i] & ((address & mask_i) == (base_i & mask_i)).
  - Lowest-index hit wins; at most one decoder bit is 0.
  - No hit: all decoder bits are 1.
- ram_we_n = ~(cpu_clk_out & ~rw), purely combinational.
- slow_hit = the winning channel has SLOW_MASK set.
- FSM (state and rdy registered, updated only on eoc; no change between eoc strobes):
  - IDLE: on eoc with slow_hit and WAIT_CYCLES>0: rdy<=0, wcnt<=WAIT_CYCLES-1, go to WAIT. Otherwise stay in IDLE with rdy=1.
  - WAIT: on eoc with wcnt==0: rdy<=1, go to DONE. Otherwise wcnt<=wcnt-1.
  - DONE: on eoc go to IDLE unconditionally. slow_hit is ignored, because this is the completing cycle of the same access and must not be re-stretched.
  - Result: each slow access lasts exactly WAIT_CYCLES+1 CPU cycles.
- Address changes while in WAIT or DONE do not alter the sequence.
- Back-to-back slow accesses: the second access is detected at the eoc after DONE returns to IDLE.
- Reset mid-WAIT: rdy returns to 1 immediately (async) and the divider restarts with counter=0.
- Counter width is clog2(DIVISOR); wcnt is 4 bits. All comparisons are unsigned.

Decomposition:
- Package herring_bus_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the address-slice width constant (6);
  - named base/mask constants for the standard map: ACIA 0x8000 = 6'b100000, VIA 0x8400 = 6'b100001, mask 6'h3F.
- One sub-module, herring_clk_div, contains counter, cpu_clk_in and the eoc output, parameterised by DIVISOR.

Test Plan:
- Reset, then run 100 clk_src cycles with DIVISOR=25 -> cpu_clk_in high for 12 and low for 13 source clocks per period; eoc every 25th clock; rdy=1 throughout.
- NUM_CS=2, ch0 base 6'b100000, ch1 base 6'b100001, both enabled, masks 6'h3F. address=6'b100001 -> decoder=2'b01. address=6'b100000 -> decoder=2'b10. address=6'b000000 -> decoder=2'b11.
- Overlap: ch0 mask 6'h20, base 6'h20; ch1 base 6'b100001. address=6'b100001 -> only decoder[0]=0.
- SLOW_MASK[1]=1, WAIT_CYCLES=2; hold address=6'b100001 across an eoc -> rdy low for exactly 2 CPU cycles (50 source clocks), then high. The following cycle is not stretched even with the address held.
- cpu_clk_out=1, rw=0 -> ram_we_n=0. rw=1 or cpu_clk_out=0 -> ram_we_n=1.
- Assert reset 5 clocks into WAIT -> rdy=1, cpu_clk_in=0 and counter=0 immediately. After release, the first eoc occurs 25 clocks later.
